// File: rtl/prbs7_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions and 32-bit word expansion,
// used by both the generator and the downstream word checker.
package prbs7_pkg;

    localparam int               PRBS7_W            = 32;
    localparam int               PRBS7_ORDER        = 7;
    localparam logic [6:0]       PRBS7_DEFAULT_SEED = 7'h7F;

    // r[0] is the oldest bit; each new bit enters at r[6]. p[0] is first in time.
    function automatic logic [PRBS7_W-1:0] prbs7_next(input logic [PRBS7_ORDER-1:0] r);
        logic [PRBS7_ORDER-1:0] c;
        logic [PRBS7_W-1:0]     p;
        c = r;
        p = '0;
        for (int i = 0; i < PRBS7_W; i++) begin
            p[i] = c[1] ^ c[0];
            c    = {p[i], c[PRBS7_ORDER-1:1]};
        end
        return p;
    endfunction

endpackage

// File: rtl/prbs7_gen32_if.sv
// Control/data bundle of the 32-bit PRBS7 generator; master drives controls,
// slave (the generator) drives the word and status outputs.
interface prbs7_gen32_if;
    import prbs7_pkg::*;

    logic                   en;
    logic                   load_seed;
    logic [PRBS7_ORDER-1:0] seed;
    logic                   inject_err;
    logic [4:0]             err_pos;
    logic [PRBS7_W-1:0]     dout;
    logic                   dout_valid;
    logic                   err_pending;
    logic [31:0]            word_cnt;
    logic [15:0]            inj_cnt;

    modport master (
        output en, load_seed, seed, inject_err, err_pos,
        input  dout, dout_valid, err_pending, word_cnt, inj_cnt
    );

    modport slave (
        input  en, load_seed, seed, inject_err, err_pos,
        output dout, dout_valid, err_pending, word_cnt, inj_cnt
    );
endinterface

// File: rtl/prbs7_err_inject.sv
// Single-bit error injection: pending flag, position latch, flip mask and a
// saturating count of applied injections.
module prbs7_err_inject
    import prbs7_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               inject_err,
    input  logic [4:0]         err_pos,
    input  logic               run,
    input  logic               clear,
    output logic [PRBS7_W-1:0] injmask,
    output logic               err_pending,
    output logic [15:0]        inj_cnt
);

    logic        pend_q, pend_d;
    logic [4:0]  pos_q, pos_d;
    logic [15:0] cnt_q, cnt_d;
    logic        apply;
    logic [4:0]  pos_sel;

    // A request arriving while one is already pending is dropped outright.
    always_comb begin
        pend_d  = pend_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        pos_sel = pend_q ? pos_q : err_pos;
        if (clear) begin
            pend_d = 1'b0;
        end else if (run) begin
            apply  = pend_q || inject_err;
            pend_d = 1'b0;
        end else if (inject_err && !pend_q) begin
            pend_d = 1'b1;
            pos_d  = err_pos;
        end
        if (apply && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        injmask = apply ? (32'd1 << pos_sel) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= 1'b0;
            pos_q  <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            pos_q  <= pos_d;
            cnt_q  <= cnt_d;
        end
    end

    assign err_pending = pend_q;
    assign inj_cnt     = cnt_q;

endmodule

// File: rtl/prbs7_gen32.sv
// 32-bit-per-clock PRBS7 generator, bit 0 first in time.
// Optional error injection is built when PRBS7_ERR_INJ_EN is defined.
//   state | meaning
//   IDLE  | no word produced this cycle, dout holds, dout_valid low
//   RUN   | a fresh word was loaded into dout this cycle
module prbs7_gen32
    import prbs7_pkg::*;
#(
    parameter logic [PRBS7_ORDER-1:0] SEED = PRBS7_DEFAULT_SEED
)(
    input logic           clk,
    input logic           rstn,
    prbs7_gen32_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam logic [PRBS7_ORDER-1:0] SEED_RST = (SEED == '0) ? PRBS7_DEFAULT_SEED : SEED;

    state_e                 state_q, state_d;
    logic [PRBS7_ORDER-1:0] r_q, r_d;
    logic [PRBS7_W-1:0]     dout_q, dout_d;
    logic [31:0]            word_cnt_q, word_cnt_d;
    logic [PRBS7_W-1:0]     p;
    logic [PRBS7_W-1:0]     injmask;

    assign p = prbs7_next(r_q);

`ifdef PRBS7_ERR_INJ_EN
    logic run;
    assign run = bus.en && !bus.load_seed;

    prbs7_err_inject u_err_inject (
        .clk         (clk),
        .rstn        (rstn),
        .inject_err  (bus.inject_err),
        .err_pos     (bus.err_pos),
        .run         (run),
        .clear       (bus.load_seed),
        .injmask     (injmask),
        .err_pending (bus.err_pending),
        .inj_cnt     (bus.inj_cnt)
    );
`else
    logic unused_inj;
    assign unused_inj      = ^{bus.inject_err, bus.err_pos};
    assign injmask         = '0;
    assign bus.err_pending = 1'b0;
    assign bus.inj_cnt     = '0;
`endif

    // State advances from the clean word so an injected flip never propagates.
    always_comb begin
        state_d    = IDLE;
        r_d        = r_q;
        dout_d     = dout_q;
        word_cnt_d = word_cnt_q;
        if (bus.load_seed) begin
            r_d        = (bus.seed == '0) ? PRBS7_DEFAULT_SEED : bus.seed;
            word_cnt_d = '0;
        end else if (bus.en) begin
            state_d    = RUN;
            r_d        = p[PRBS7_W-1:PRBS7_W-PRBS7_ORDER];
            dout_d     = p ^ injmask;
            word_cnt_d = word_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            r_q        <= SEED_RST;
            dout_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            dout_q     <= dout_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = (state_q == RUN);
    assign bus.word_cnt   = word_cnt_q;

endmodule
